reorder_nbank: RTL and testbench
================================

Name: reorder_nbank

Overview:
- N-bank generalisation of the double-buffered reorder FIFO.
- Unordered (data, offset) beats fill banks round-robin; a bank locks when its frame is complete.
- Locked banks drain in strict offset order 0..len-1 to an ordered ready/valid output, also round-robin.
- Adds per-frame programmable length, offset/duplicate error detection and bank status. It sits between the unordered producer (if1) and the ordered consumer (if2).

Parameters:
- DW, 32, data width
- AW, 10, offset width; bank depth is 2**AW entries
- NBANK, 4, number of banks; legal values are 2..16
- BW, $clog2(NBANK), bank-pointer width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_len  in  AW+1  frame length; sampled when a bank opens for writing
- if1_dut_data  in  DW  unordered data
- if1_dut_offset  in  AW  position of the beat within the frame
- if1_dut_vld  in  1  producer valid
- dut_if1_rdy  out  1  block can accept a beat
- dut_if2_data  out  DW  ordered data
- dut_if2_vld  out  1  ordered data valid
- if2_dut_rdy  in  1  consumer ready
- bank_locked  out  NBANK  per-bank locked (full, awaiting drain) flag
- err_oor  out  1  one-cycle pulse: accepted offset >= frame length; beat dropped
- err_dup  out  1  one-cycle pulse: offset already written in this frame; data overwritten

Behaviour:
- Reset values: all banks unlocked, wr_ptr=0, rd_ptr=0, rd_idx=0, all valid bitmaps and counts cleared, dut_if1_rdy=1 from the first cycle after reset, dut_if2_vld=0, err_oor=0, err_dup=0, bank_locked=0, dut_if2_data=0.
- Reset asserted mid-frame discards all banks; there is no partial drain.
- Frame length: eff_len = cfg_len when 1 <= cfg_len <= 2**AW; otherwise eff_len = 2**AW.
- eff_len is latched into len[b] on reset for bank 0, and on the cycle bank b becomes the write bank.
- cfg_len changes have no effect on a bank that is already open.
- Write side:
  - dut_if1_rdy = !locked[wr_ptr]. A beat is accepted when if1_dut_vld && dut_if1_rdy.
  - offset >= len[wr_ptr]: drop the beat, pulse err_oor the next cycle, leave count unchanged.
  - valid bit already set for the offset: overwrite the data, pulse err_dup the next cycle, leave count unchanged.
  - Otherwise: store the data, set the valid bit, count += 1.
  - When a new beat makes count == len[wr_ptr]: on that edge locked[wr_ptr] <= 1, wr_ptr <= wr_ptr+1 (mod NBANK), bitmap cleared, len latched for the next bank.
  - dut_if1_rdy for the next bank is evaluated on the following cycle.
- Read side:
  - dut_if2_vld = locked[rd_ptr]; dut_if2_data = bank[rd_ptr][rd_idx], combinational from the storage array.
  - dut_if2_data is 0 when dut_if2_vld is low.
  - Pop = dut_if2_vld && if2_dut_rdy. rd_idx += 1 on each pop.
  - On a pop with rd_idx == len[rd_ptr]-1: locked[rd_ptr] <= 0, rd_ptr++ (mod NBANK), rd_idx <= 0.
- Latency: the last beat accepted at edge N gives dut_if2_vld=1 at cycle N+1, provided that bank is rd_ptr.
- Output throughput is 1 beat/cycle. Consecutive locked banks drain back-to-back with no bubble.
- Full condition: all NBANK banks locked means dut_if1_rdy=0.
- Simultaneous events:
  - In the same cycle, a last pop of bank k and acceptance of the completing beat of bank j (j != k) are both honoured.
  - A bank freed by the reader at edge N is writable at cycle N+1. There is no same-cycle bypass.
- Wrap-around: pointers wrap NBANK-1 -> 0. NBANK need not be a power of 2; wrap uses explicit compare.
- Arithmetic: count and rd_idx are AW+1 bits, so 2**AW is representable. Offset compare is zero-extended to AW+1.

Decomposition:
- Package reorder_pkg:
  - localparam helpers: eff_len clamp function.
  - typedef for bank pointer: logic [BW-1:0].
  - typedef for count/length: logic [AW:0].
- Sub-module reorder_bank, instantiated NBANK times via generate:
  - Contains the 2**AW x DW storage, valid bitmap, count and latched len.
  - Outputs frame_done, dup and oor.
- Top level contains:
  - wr_ptr/rd_ptr/rd_idx registers and lock flags.
  - Steering muxes to and from the banks.
  - Registered error pulses.

Test Plan:
- In-order fill: NBANK=4, AW=3, cfg_len=8; offsets 0..7 with data 0x10..0x17, consumer always ready -> if2 yields 0x10..0x17 in order; dut_if2_vld first high 1 cycle after the 8th accept; bank_locked=4'b0001 for exactly 8 cycles.
- Reverse-order fill: offsets 7..0 with data D7..D0 -> output D0..D7; no err pulses.
- Backpressure fill-all: if2_dut_rdy=0; 4 frames of 8 -> bank_locked=4'b1111, dut_if1_rdy=0. Release rdy -> 32 ordered beats with no bubbles; rdy rises the cycle after bank 0's last pop.
- Short frames and clamp: cfg_len=3, then cfg_len=0 -> bank 0 locks after 3 beats; bank 1 needs 8 beats (0 clamps to 2**AW=8); output counts are 3 then 8.
- Errors: cfg_len=4; send offset 5 -> err_oor pulse, beat dropped; send offset 2 twice with data A then B -> err_dup pulse; frame completes after offsets 0,1,3 and outputs slot 2 = B.
- Reset mid-operation: after 3 of 8 beats in bank 0 and bank 1 half-drained, assert rst_n=0 for 1 cycle -> all outputs return to reset values; a fresh 8-beat frame then drains from bank 0 correctly.

Source files
------------

// File: rtl/reorder_pkg.sv
// Shared types and helpers for the N-bank reorder buffer.
package reorder_pkg;

  // Outcome of one beat presented to the write bank.
  typedef enum logic [1:0] {
    WR_NONE,
    WR_STORE,
    WR_DUP,
    WR_OOR
  } wr_kind_t;

  // Frame length actually used: an out-of-range request means a full-depth frame.
  function automatic int unsigned eff_len(input int unsigned cfg, input int unsigned aw);
    int unsigned depth;
    depth = 32'd1 << aw;
    if (cfg >= 1 && cfg <= depth) return cfg;
    return depth;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// One reorder bank: frame storage, per-offset valid bitmap, fill count and frame length.
module reorder_bank
  import reorder_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_len,
  input  logic [AW:0]   new_len,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_offset,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   frame_len,
  output logic          frame_done,
  output logic          dup,
  output logic          oor
);

  localparam int DEPTH = 1 << AW;

  typedef logic [AW:0] len_t;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] vbits;
  len_t             count;
  len_t             len;
  len_t             drain_len;
  wr_kind_t         kind;

  // Classify the incoming beat against the frame length and the valid bitmap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    kind = WR_NONE;
    if (wr_en) begin
      if ({1'b0, wr_offset} >= len) kind = WR_OOR;
      else if (vbits[wr_offset])    kind = WR_DUP;
      else                          kind = WR_STORE;
    end
  end

  assign oor        = (kind == WR_OOR);
  assign dup        = (kind == WR_DUP);
  assign frame_done = (kind == WR_STORE) && (count + 1'b1 == len);
  assign rd_data    = mem[rd_addr];
  assign frame_len  = drain_len;

  // Data storage; duplicates overwrite, out-of-range beats are dropped.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the valid bitmap alone decides what is meaningful.
    if (kind == WR_STORE || kind == WR_DUP) mem[wr_offset] <= wr_data;
  end

  // Bitmap, count and length bookkeeping; a completed frame snapshots its length for the reader.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      vbits     <= '0;
      count     <= '0;
      len       <= new_len;
      drain_len <= '0;
    end else begin
      if (frame_done) begin
        vbits     <= '0;
        count     <= '0;
        drain_len <= len;
      end else if (kind == WR_STORE) begin
        vbits[wr_offset] <= 1'b1;
        count            <= count + 1'b1;
      end
      if (load_len) len <= new_len;
    end
  end

endmodule

// File: rtl/reorder_nbank.sv
// N-bank reorder buffer: unordered (data, offset) beats in, frames out in offset order.
module reorder_nbank
  import reorder_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 10,
  parameter int NBANK = 4,
  localparam int BW   = $clog2(NBANK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW:0]      cfg_len,
  input  logic [DW-1:0]    if1_dut_data,
  input  logic [AW-1:0]    if1_dut_offset,
  input  logic             if1_dut_vld,
  output logic             dut_if1_rdy,
  output logic [DW-1:0]    dut_if2_data,
  output logic             dut_if2_vld,
  input  logic             if2_dut_rdy,
  output logic [NBANK-1:0] bank_locked,
  output logic             err_oor,
  output logic             err_dup
);

  typedef logic [BW-1:0] ptr_t;
  typedef logic [AW:0]   len_t;

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  len_t             rd_idx;
  logic [NBANK-1:0] locked;

  logic [DW-1:0]    bank_rd_data [NBANK];
  len_t             bank_len     [NBANK];
  logic [NBANK-1:0] bank_wr_en;
  logic [NBANK-1:0] bank_load;
  logic [NBANK-1:0] bank_done;
  logic [NBANK-1:0] bank_dup;
  logic [NBANK-1:0] bank_oor;

  len_t cfg_eff;
  logic accept;
  logic frame_done;
  logic pop;
  logic last_pop;

  // Pointer increment with explicit wrap so NBANK need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(NBANK - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cfg_eff    = len_t'(eff_len(32'(cfg_len), AW));
  assign dut_if1_rdy = !locked[wr_ptr];
  assign accept     = if1_dut_vld && dut_if1_rdy;
  assign frame_done = |bank_done;

  assign dut_if2_vld  = locked[rd_ptr];
  assign dut_if2_data = dut_if2_vld ? bank_rd_data[rd_ptr] : '0;
  assign pop          = dut_if2_vld && if2_dut_rdy;
  assign last_pop     = pop && (rd_idx == bank_len[rd_ptr] - 1'b1);
  assign bank_locked  = locked;

  // Steer the write strobe to the write bank and the length load to the next one.
  always_comb begin
    bank_wr_en = '0;
    bank_load  = '0;
    bank_wr_en[wr_ptr]          = accept;
    bank_load[ptr_inc(wr_ptr)]  = frame_done;
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    reorder_bank #(
      .DW(DW),
      .AW(AW)
    ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_len   (bank_load[b]),
      .new_len    (cfg_eff),
      .wr_en      (bank_wr_en[b]),
      .wr_offset  (if1_dut_offset),
      .wr_data    (if1_dut_data),
      .rd_addr    (rd_idx[AW-1:0]),
      .rd_data    (bank_rd_data[b]),
      .frame_len  (bank_len[b]),
      .frame_done (bank_done[b]),
      .dup        (bank_dup[b]),
      .oor        (bank_oor[b])
    );
  end

  // Lock flags and pointers; the completing bank is never the draining bank, so both updates apply.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      locked <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_idx <= '0;
    end else begin
      if (frame_done) begin
        locked[wr_ptr] <= 1'b1;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (last_pop) begin
        locked[rd_ptr] <= 1'b0;
        rd_ptr         <= ptr_inc(rd_ptr);
        rd_idx         <= '0;
      end else if (pop) begin
        rd_idx <= rd_idx + 1'b1;
      end
    end
  end

  // Error pulses appear the cycle after the offending beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_oor <= 1'b0;
      err_dup <= 1'b0;
    end else begin
      err_oor <= |bank_oor;
      err_dup <= |bank_dup;
    end
  end

endmodule

// File: tb/tb_reorder_nbank.sv
// Self-checking bench for reorder_nbank (DW=32, AW=3, NBANK=4).
module tb_reorder_nbank;

  localparam int DW    = 32;
  localparam int AW    = 3;
  localparam int NBANK = 4;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [AW:0]      cfg_len;
  logic [DW-1:0]    if1_dut_data;
  logic [AW-1:0]    if1_dut_offset;
  logic             if1_dut_vld;
  logic             dut_if1_rdy;
  logic [DW-1:0]    dut_if2_data;
  logic             dut_if2_vld;
  logic             if2_dut_rdy;
  logic [NBANK-1:0] bank_locked;
  logic             err_oor;
  logic             err_dup;

  int checks   = 0;
  int failures = 0;

  reorder_nbank #(.DW(DW), .AW(AW), .NBANK(NBANK)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_len        (cfg_len),
    .if1_dut_data   (if1_dut_data),
    .if1_dut_offset (if1_dut_offset),
    .if1_dut_vld    (if1_dut_vld),
    .dut_if1_rdy    (dut_if1_rdy),
    .dut_if2_data   (dut_if2_data),
    .dut_if2_vld    (dut_if2_vld),
    .if2_dut_rdy    (if2_dut_rdy),
    .bank_locked    (bank_locked),
    .err_oor        (err_oor),
    .err_dup        (err_dup)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frames are numbered in completion order; frame k lives in bank k mod NBANK.
  logic [DW-1:0] exp_q[$];
  int            flen_q[$];
  int            done_cnt, drain_cnt;
  logic [DW-1:0] m_buf [DEPTH];
  bit            m_vb  [DEPTH];
  int            m_len, m_cnt;
  bit            m_oor, m_dup, m_acc, m_pop, live = 0;

  logic [DW-1:0] out_log[$];
  int            n_oor, n_dup;

  function automatic int m_eff(input int c);
    return (c == 0 || c > DEPTH) ? DEPTH : c;
  endfunction

  function automatic logic [NBANK-1:0] m_locked();
    logic [NBANK-1:0] v = '0;
    for (int i = drain_cnt; i < done_cnt; i++) v[i % NBANK] = 1'b1;
    return v;
  endfunction

  // Compare at the negedge, then advance the model to the state after the next posedge.
  always @(negedge clk) begin
    if (live) begin
      check("if1_rdy",  dut_if1_rdy, (done_cnt - drain_cnt) < NBANK);
      check("if2_vld",  dut_if2_vld, done_cnt > drain_cnt);
      check("if2_data", dut_if2_data, (done_cnt > drain_cnt) ? exp_q[0] : '0);
      check("locked",   bank_locked, m_locked());
      check("err_oor",  err_oor, m_oor);
      check("err_dup",  err_dup, m_dup);
    end
    if (rst_n && dut_if2_vld && if2_dut_rdy) out_log.push_back(dut_if2_data);
    if (err_oor) n_oor++;
    if (err_dup) n_dup++;

    if (!rst_n) begin
      exp_q = {}; flen_q = {};
      done_cnt = 0; drain_cnt = 0;
      m_len = m_eff(int'(cfg_len)); m_cnt = 0;
      for (int i = 0; i < DEPTH; i++) m_vb[i] = 0;
      m_oor = 0; m_dup = 0;
      live = 1;
    end else if (live) begin
      m_acc = if1_dut_vld && ((done_cnt - drain_cnt) < NBANK);
      m_pop = (done_cnt > drain_cnt) && if2_dut_rdy;
      m_oor = 0; m_dup = 0;
      if (m_pop) begin
        void'(exp_q.pop_front());
        flen_q[0] = flen_q[0] - 1;
        if (flen_q[0] == 0) begin
          void'(flen_q.pop_front());
          drain_cnt++;
        end
      end
      if (m_acc) begin
        if (int'(if1_dut_offset) >= m_len) begin
          m_oor = 1;
        end else if (m_vb[if1_dut_offset]) begin
          m_buf[if1_dut_offset] = if1_dut_data;
          m_dup = 1;
        end else begin
          m_buf[if1_dut_offset] = if1_dut_data;
          m_vb[if1_dut_offset]  = 1;
          m_cnt++;
          if (m_cnt == m_len) begin
            for (int i = 0; i < m_len; i++) exp_q.push_back(m_buf[i]);
            flen_q.push_back(m_len);
            done_cnt++;
            m_cnt = 0;
            for (int i = 0; i < DEPTH; i++) m_vb[i] = 0;
            m_len = m_eff(int'(cfg_len));
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input int len, input int cycles);
    if1_dut_vld = 1'b0;
    rst_n   = 1'b0;
    cfg_len = (AW+1)'(len);
    repeat (cycles) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input int off, input logic [DW-1:0] d);
    int n = 0;
    if1_dut_vld    = 1'b1;
    if1_dut_offset = AW'(off);
    if1_dut_data   = d;
    while (!dut_if1_rdy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("send_accept_in_time", n < 500, 1'b1);
    @(posedge clk); #1;
    if1_dut_vld = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((dut_if2_vld || bank_locked != '0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_in_time", n < 500, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, rise_at;
    rst_n = 1'b0; cfg_len = '0; if1_dut_vld = 1'b0;
    if1_dut_offset = '0; if1_dut_data = '0; if2_dut_rdy = 1'b1;

    // Reset values
    do_reset(8, 2);
    check("rst_if1_rdy", dut_if1_rdy, 1'b1);
    check("rst_if2_vld", dut_if2_vld, 1'b0);
    check("rst_if2_data", dut_if2_data, 0);
    check("rst_locked", bank_locked, 4'b0000);
    check("rst_errs", {err_oor, err_dup}, 2'b00);

    // In-order fill, consumer always ready
    out_log = {};
    for (int i = 0; i < 8; i++) send(i, DW'(32'h10 + i));
    check("t1_vld_latency", dut_if2_vld, 1'b1);
    check("t1_locked", bank_locked, 4'b0001);
    check("t1_first_data", dut_if2_data, 32'h10);
    n = 0;
    while (bank_locked == 4'b0001 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    check("t1_lock_cycles", n, 8);
    check("t1_out_count", out_log.size(), 8);
    for (int i = 0; i < out_log.size(); i++) check("t1_out_data", out_log[i], 32'h10 + i);

    // Reverse-order fill
    do_reset(8, 1);
    out_log = {}; n_oor = 0; n_dup = 0;
    for (int i = 7; i >= 0; i--) send(i, DW'(32'hA0 + i));
    wait_idle();
    check("t2_out_count", out_log.size(), 8);
    for (int i = 0; i < out_log.size(); i++) check("t2_out_data", out_log[i], 32'hA0 + i);
    check("t2_no_errs", n_oor + n_dup, 0);

    // Backpressure: fill all four banks, then release
    do_reset(8, 1);
    out_log = {};
    if2_dut_rdy = 1'b0;
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 8; i++) send((i * 3) % 8, DW'(32'h200 + f * 8 + (i * 3) % 8));
    check("t3_all_locked", bank_locked, 4'b1111);
    check("t3_full_rdy", dut_if1_rdy, 1'b0);
    if2_dut_rdy = 1'b1;
    n = 0; rise_at = -1;
    while (dut_if2_vld && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (dut_if1_rdy && rise_at < 0) rise_at = n;
    end
    check("t3_burst_len", n, 32);
    check("t3_rdy_rise", rise_at, 8);
    check("t3_out_count", out_log.size(), 32);
    for (int i = 0; i < out_log.size(); i++) check("t3_out_data", out_log[i], 32'h200 + i);

    // Short frame then clamped length
    do_reset(3, 1);
    out_log = {};
    send(0, 32'h30);
    send(1, 32'h31);
    cfg_len = '0;
    send(2, 32'h32);
    check("t4_bank0_locked", bank_locked[0], 1'b1);
    cfg_len = 5;
    for (int i = 0; i < 7; i++) send(i, DW'(32'h40 + i));
    check("t4_bank1_open_after7", bank_locked[1], 1'b0);
    send(7, 32'h47);
    check("t4_bank1_locked_after8", bank_locked[1], 1'b1);
    wait_idle();
    check("t4_out_count", out_log.size(), 11);
    for (int i = 0; i < 3 && i < out_log.size(); i++) check("t4_out_f0", out_log[i], 32'h30 + i);
    for (int i = 3; i < out_log.size(); i++) check("t4_out_f1", out_log[i], 32'h40 + i - 3);

    // Offset and duplicate errors
    do_reset(4, 1);
    out_log = {}; n_oor = 0; n_dup = 0;
    send(5, 32'hBAD);
    check("t5_err_oor", err_oor, 1'b1);
    send(2, 32'hA);
    check("t5_oor_clears", err_oor, 1'b0);
    send(2, 32'hB);
    check("t5_err_dup", err_dup, 1'b1);
    send(0, 32'hC0);
    send(1, 32'hC1);
    check("t5_not_locked_yet", bank_locked, 4'b0000);
    send(3, 32'hC3);
    wait_idle();
    check("t5_out_count", out_log.size(), 4);
    if (out_log.size() == 4) begin
      check("t5_slot0", out_log[0], 32'hC0);
      check("t5_slot1", out_log[1], 32'hC1);
      check("t5_slot2", out_log[2], 32'hB);
      check("t5_slot3", out_log[3], 32'hC3);
    end
    check("t5_pulse_counts", {n_oor[7:0], n_dup[7:0]}, 16'h0101);

    // Reset in the middle of operation
    do_reset(8, 1);
    if2_dut_rdy = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) send(i, DW'(32'h50 + f * 8 + i));
    if2_dut_rdy = 1'b1;
    repeat (12) @(posedge clk);
    #1 if2_dut_rdy = 1'b0;
    for (int f = 2; f < 4; f++)
      for (int i = 0; i < 8; i++) send(i, DW'(32'h50 + f * 8 + i));
    for (int i = 0; i < 3; i++) send(i, DW'(32'h70 + i));
    check("t6_pre_reset_locked", bank_locked, 4'b1110);
    do_reset(8, 1);
    check("t6_rst_if1_rdy", dut_if1_rdy, 1'b1);
    check("t6_rst_if2_vld", dut_if2_vld, 1'b0);
    check("t6_rst_data", dut_if2_data, 0);
    check("t6_rst_locked", bank_locked, 4'b0000);
    check("t6_rst_errs", {err_oor, err_dup}, 2'b00);
    out_log = {};
    if2_dut_rdy = 1'b1;
    for (int i = 0; i < 8; i++) send(7 - i, DW'(32'h80 + 7 - i));
    wait_idle();
    check("t6_out_count", out_log.size(), 8);
    for (int i = 0; i < out_log.size(); i++) check("t6_out_data", out_log[i], 32'h80 + i);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
